// File: rtl/lsu_dmem_ctrl_if.sv
// Core request/response handshake and word-wide dmem port of the LSU.
// master is the LSU side, slave is the core plus memory side.
interface lsu_dmem_ctrl_if #(
    parameter int WIDTH = 32
);
    logic             req_valid;
    logic             req_ready;
    logic             req_we;
    logic [2:0]       req_funct3;
    logic [WIDTH-1:0] req_addr;
    logic [WIDTH-1:0] req_wdata;
    logic             resp_valid;
    logic             resp_err;
    logic [WIDTH-1:0] resp_rdata;
    logic             dmem_sel;
    logic [WIDTH-1:0] dmem_addr;
    logic [WIDTH-1:0] dmem_wdata;
    logic [WIDTH-1:0] dmem_rdata;

    modport master (
        input  req_valid, req_we, req_funct3, req_addr, req_wdata,
        input  dmem_rdata,
        output req_ready, resp_valid, resp_err, resp_rdata,
        output dmem_sel, dmem_addr, dmem_wdata
    );

    modport slave (
        output req_valid, req_we, req_funct3, req_addr, req_wdata,
        output dmem_rdata,
        input  req_ready, resp_valid, resp_err, resp_rdata,
        input  dmem_sel, dmem_addr, dmem_wdata
    );
endinterface

// File: rtl/lsu_dmem_ctrl.sv
// Load/store unit front end: one request at a time, sub-word stores
// done as read-modify-write on a word-only data memory.
module lsu_dmem_ctrl #(
    parameter int WIDTH     = 32,
    parameter int MEM_DEPTH = 1024
) (
    input  logic               clk,
    input  logic               rst,
    lsu_dmem_ctrl_if.master    bus
);
    typedef enum logic [2:0] {
        IDLE, LOAD, RMW_RD, WRITE, RESP, ERR
    } state_e;

    state_e            state_q;
    logic [2:0]        f3_q;
    logic [1:0]        off_q;
    logic [15:0]       wdata_q;
    logic              sel_q;
    logic [WIDTH-1:0]  addr_q;
    logic [WIDTH-1:0]  wd_q;
    logic              rv_q;
    logic              re_q;
    logic [WIDTH-1:0]  rd_q;

    logic [1:0]        sz_m1;
    logic              f3_bad;
    logic              mis;
    logic [WIDTH:0]    end_addr;
    logic              oor;
    logic              bad;
    logic [WIDTH-1:0]  word_addr;
    logic [7:0]        lane_b;
    logic [15:0]       lane_h;
    logic [WIDTH-1:0]  ld_data;
    logic [WIDTH-1:0]  merged;

    assign bus.req_ready  = (state_q == IDLE) && !rst;
    // Gate with rst so a reset arriving in WRITE never commits the word.
    assign bus.dmem_sel   = sel_q && !rst;
    assign bus.dmem_addr  = addr_q;
    assign bus.dmem_wdata = wd_q;
    assign bus.resp_valid = rv_q;
    assign bus.resp_err   = re_q;
    assign bus.resp_rdata = rd_q;
    assign word_addr      = {bus.req_addr[WIDTH-1:2], 2'b00};

    always_comb begin
        sz_m1 = 2'd3;
        case (bus.req_funct3[1:0])
            2'b00:   sz_m1 = 2'd0;
            2'b01:   sz_m1 = 2'd1;
            default: sz_m1 = 2'd3;
        endcase
        if (bus.req_we) begin
            f3_bad = bus.req_funct3 > 3'd2;
        end else begin
            f3_bad = (bus.req_funct3 == 3'b011)
                  || (bus.req_funct3[2:1] == 2'b11);
        end
        mis = ((bus.req_funct3[1:0] == 2'b01) && bus.req_addr[0])
           || ((bus.req_funct3[1:0] == 2'b10)
               && (bus.req_addr[1:0] != 2'b00));
        end_addr = {1'b0, bus.req_addr} + (WIDTH+1)'(sz_m1);
        oor = end_addr >= (WIDTH+1)'(MEM_DEPTH);
        bad = f3_bad || mis || oor;
    end

    always_comb begin
        lane_b  = bus.dmem_rdata[{off_q, 3'b000} +: 8];
        lane_h  = bus.dmem_rdata[{off_q[1], 4'b0000} +: 16];
        ld_data = bus.dmem_rdata;
        case (f3_q)
            3'b000:  ld_data = {{24{lane_b[7]}}, lane_b};
            3'b001:  ld_data = {{16{lane_h[15]}}, lane_h};
            3'b100:  ld_data = {24'd0, lane_b};
            3'b101:  ld_data = {16'd0, lane_h};
            default: ld_data = bus.dmem_rdata;
        endcase
        merged = bus.dmem_rdata;
        if (f3_q[1:0] == 2'b00) begin
            merged[{off_q, 3'b000} +: 8] = wdata_q[7:0];
        end else begin
            merged[{off_q[1], 4'b0000} +: 16] = wdata_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            f3_q    <= '0;
            off_q   <= '0;
            wdata_q <= '0;
            sel_q   <= 1'b0;
            addr_q  <= '0;
            wd_q    <= '0;
            rv_q    <= 1'b0;
            re_q    <= 1'b0;
            rd_q    <= '0;
        end else begin
            rv_q  <= 1'b0;
            re_q  <= 1'b0;
            sel_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (bus.req_valid) begin
                        f3_q    <= bus.req_funct3;
                        off_q   <= bus.req_addr[1:0];
                        wdata_q <= bus.req_wdata[15:0];
                        if (bad) begin
                            state_q <= ERR;
                            rv_q    <= 1'b1;
                            re_q    <= 1'b1;
                            rd_q    <= '0;
                        end else if (!bus.req_we) begin
                            state_q <= LOAD;
                            addr_q  <= word_addr;
                        end else if (bus.req_funct3[1:0] == 2'b10) begin
                            state_q <= WRITE;
                            addr_q  <= word_addr;
                            wd_q    <= bus.req_wdata;
                            sel_q   <= 1'b1;
                        end else begin
                            state_q <= RMW_RD;
                            addr_q  <= word_addr;
                        end
                    end
                end
                LOAD: begin
                    state_q <= RESP;
                    addr_q  <= '0;
                    rv_q    <= 1'b1;
                    rd_q    <= ld_data;
                end
                RMW_RD: begin
                    state_q <= WRITE;
                    wd_q    <= merged;
                    sel_q   <= 1'b1;
                end
                WRITE: begin
                    state_q <= RESP;
                    addr_q  <= '0;
                    rv_q    <= 1'b1;
                    rd_q    <= '0;
                end
                RESP:    state_q <= IDLE;
                ERR:     state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_lsu_dmem_ctrl.sv
// Directed bench for lsu_dmem_ctrl with a word-wide memory model.
// Inputs change on negedge; outputs are checked on negedge.
module tb_lsu_dmem_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad = 0;
    int   sel_cnt = 0;
    int   acc_cnt = 0;
    logic        prev_sel = 1'b0;
    logic [31:0] last_wa = '0;
    logic [31:0] last_wd = '0;
    logic [31:0] mem [256];

    always #5 clk = ~clk;

    lsu_dmem_ctrl_if #(.WIDTH(32)) bus ();

    lsu_dmem_ctrl #(
        .WIDTH(32),
        .MEM_DEPTH(1024)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    assign bus.dmem_rdata = mem[bus.dmem_addr[9:2]];

    always @(posedge clk) begin
        if (bus.dmem_sel) begin
            mem[bus.dmem_addr[9:2]] <= bus.dmem_wdata;
            sel_cnt <= sel_cnt + 1;
            last_wa <= bus.dmem_addr;
            last_wd <= bus.dmem_wdata;
        end
        if (bus.req_valid && bus.req_ready) acc_cnt <= acc_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (bus.dmem_sel) chk("sel_single", {31'd0, prev_sel}, 32'd0);
        prev_sel = bus.dmem_sel;
    end

    task automatic txn(input string tag, input bit we,
                       input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd, input bit hold,
                       input int exp_lat, input bit exp_err,
                       input logic [31:0] exp_rd, input logic [31:0] exp_wd);
        int  lat;
        int  s0;
        int  a0;
        bit  got;
        for (int i = 0; i < 20 && !bus.req_ready; i++) @(negedge clk);
        chk({tag, ".ready"}, {31'd0, bus.req_ready}, 32'd1);
        s0 = sel_cnt;
        a0 = acc_cnt;
        bus.req_valid  = 1'b1;
        bus.req_we     = we;
        bus.req_funct3 = f3;
        bus.req_addr   = a;
        bus.req_wdata  = wd;
        @(negedge clk);
        if (!hold) bus.req_valid = 1'b0;
        lat = 1;
        got = 1'b0;
        while (!got && lat < 10) begin
            if (bus.resp_valid) got = 1'b1;
            else begin
                @(negedge clk);
                lat++;
            end
        end
        bus.req_valid = 1'b0;
        chk({tag, ".resp_seen"}, {31'd0, got}, 32'd1);
        chk({tag, ".latency"}, 32'(lat), 32'(exp_lat));
        chk({tag, ".err"}, {31'd0, bus.resp_err}, {31'd0, exp_err});
        chk({tag, ".rdata"}, bus.resp_rdata, exp_rd);
        chk({tag, ".accepts"}, 32'(acc_cnt - a0), 32'd1);
        if (we && !exp_err) begin
            chk({tag, ".writes"}, 32'(sel_cnt - s0), 32'd1);
            chk({tag, ".waddr"}, last_wa, {a[31:2], 2'b00});
            chk({tag, ".wdata"}, last_wd, exp_wd);
        end else begin
            chk({tag, ".writes"}, 32'(sel_cnt - s0), 32'd0);
        end
    endtask

    initial begin
        int s0;
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        mem[0]   = 32'h11223344;
        mem[2]   = 32'hDEADBEEF;
        mem[255] = 32'hCAFEF00D;
        bus.req_valid  = 1'b0;
        bus.req_we     = 1'b0;
        bus.req_funct3 = 3'd0;
        bus.req_addr   = '0;
        bus.req_wdata  = '0;

        repeat (2) @(negedge clk);
        chk("rst.ready", {31'd0, bus.req_ready}, 32'd0);
        chk("rst.rvalid", {31'd0, bus.resp_valid}, 32'd0);
        chk("rst.sel", {31'd0, bus.dmem_sel}, 32'd0);
        chk("rst.daddr", bus.dmem_addr, 32'd0);
        chk("rst.rdata", bus.resp_rdata, 32'd0);
        rst = 1'b0;
        #1;
        chk("rst.ready_after", {31'd0, bus.req_ready}, 32'd1);
        @(negedge clk);

        txn("lb9", 0, 3'b000, 32'h9, 0, 0, 2, 0, 32'hFFFFFFBE, 0);
        txn("lbu9", 0, 3'b100, 32'h9, 0, 0, 2, 0, 32'h000000BE, 0);
        txn("lhA", 0, 3'b001, 32'hA, 0, 0, 2, 0, 32'hFFFFDEAD, 0);
        txn("lw8", 0, 3'b010, 32'h8, 0, 0, 2, 0, 32'hDEADBEEF, 0);
        txn("lw3fc", 0, 3'b010, 32'h3FC, 0, 0, 2, 0, 32'hCAFEF00D, 0);
        txn("sw4", 1, 3'b010, 32'h4, 32'hAAAAAAAA, 0, 2, 0, 0,
            32'hAAAAAAAA);
        txn("lw4", 0, 3'b010, 32'h4, 0, 0, 2, 0, 32'hAAAAAAAA, 0);
        txn("shA", 1, 3'b001, 32'hA, 32'h1234AAAA, 0, 3, 0, 0,
            32'hAAAABEEF);
        txn("sbB", 1, 3'b000, 32'hB, 32'h00000055, 0, 3, 0, 0,
            32'h55AABEEF);
        txn("lhuA", 0, 3'b101, 32'hA, 0, 0, 2, 0, 32'h000055AA, 0);
        txn("lb8", 0, 3'b000, 32'h8, 0, 0, 2, 0, 32'hFFFFFFEF, 0);

        txn("e_lw6", 0, 3'b010, 32'h6, 0, 0, 1, 1, 0, 0);
        txn("e_sh3", 1, 3'b001, 32'h3, 32'hFFFF, 0, 1, 1, 0, 0);
        txn("e_lw400", 0, 3'b010, 32'h400, 0, 0, 1, 1, 0, 0);
        txn("e_ld011", 0, 3'b011, 32'h0, 0, 0, 1, 1, 0, 0);
        txn("e_st100", 1, 3'b100, 32'h0, 32'h1, 0, 1, 1, 0, 0);
        txn("e_sb400", 1, 3'b000, 32'h400, 32'h1, 0, 1, 1, 0, 0);

        // SB then reset during its WRITE cycle
        s0 = sel_cnt;
        bus.req_valid  = 1'b1;
        bus.req_we     = 1'b1;
        bus.req_funct3 = 3'b000;
        bus.req_addr   = 32'h0;
        bus.req_wdata  = 32'h99;
        @(negedge clk);
        bus.req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("abort.sel", {31'd0, bus.dmem_sel}, 32'd0);
        chk("abort.ready", {31'd0, bus.req_ready}, 32'd0);
        @(negedge clk);
        chk("abort.rvalid", {31'd0, bus.resp_valid}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("abort.ready_after", {31'd0, bus.req_ready}, 32'd1);
        chk("abort.nowrite", 32'(sel_cnt - s0), 32'd0);
        chk("abort.rvalid2", {31'd0, bus.resp_valid}, 32'd0);
        @(negedge clk);
        txn("lw0", 0, 3'b010, 32'h0, 0, 0, 2, 0, 32'h11223344, 0);

        // req_valid held high through the whole store
        txn("swC", 1, 3'b010, 32'hC, 32'hDEAFBACD, 1, 2, 0, 0,
            32'hDEAFBACD);
        @(negedge clk);
        chk("b2b.ready", {31'd0, bus.req_ready}, 32'd1);
        txn("lwC", 0, 3'b010, 32'hC, 0, 0, 2, 0, 32'hDEAFBACD, 0);

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end
endmodule
